// File: rtl/mfp_uart_tx_pkg.sv
// rtl/mfp_uart_tx_pkg.sv - shared UART constants, FSM encoding and baud divisor helper
package mfp_uart_tx_pkg;

  // Transmit FSM encoding, shared with the receive side
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_t;

  localparam int UART_DATA_BITS = 8;

  // Clocks per bit, rounded to nearest
  function automatic int calc_div(input int clk_freq, input int baud);
    return (clk_freq + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/mfp_uart_fifo.sv
// rtl/mfp_uart_fifo.sv - synchronous byte FIFO with full/empty/count, flushed on reset
module mfp_uart_fifo #(
  parameter int FIFO_DEPTH = 16
) (
  input  logic                        clk,
  input  logic                        resetn,
  input  logic                        wr,
  input  logic [7:0]                  wr_data,
  input  logic                        rd,
  output logic [7:0]                  rd_data,
  output logic                        full,
  output logic                        empty,
  output logic [$clog2(FIFO_DEPTH):0] count
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_wr;
  logic          do_rd;

  // Full/empty come from registered occupancy only
  assign full    = (count == (AW + 1)'(FIFO_DEPTH));
  assign empty   = (count == '0);
  assign do_wr   = wr & ~full;
  assign do_rd   = rd & ~empty;
  assign rd_data = mem[rd_ptr];

  // Pointers and occupancy; pointers wrap naturally at FIFO_DEPTH
  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset; pointers define validity
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/mfp_uart_tx.sv
// rtl/mfp_uart_tx.sv - FIFO-fed UART transmitter, 8N1 (8E1 with MFP_UART_TX_PARITY_EN)
module mfp_uart_tx
  import mfp_uart_tx_pkg::*;
#(
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                        SI_ClkIn,
  input  logic                        SI_Reset_N,
  input  logic                        tx_wr,
  input  logic [7:0]                  tx_data,
  input  logic                        tx_ovf_clr,
  output logic                        tx_full,
  output logic                        tx_empty,
  output logic                        tx_busy,
  output logic [$clog2(FIFO_DEPTH):0] tx_count,
  output logic                        tx_ovf,
  output logic                        UART_TX
);

  localparam int            DIV       = calc_div(CLK_FREQ, BAUD);
  localparam int            BW        = $clog2(DIV + 1);
  localparam logic [BW-1:0] BAUD_LAST = BW'(DIV - 1);

  uart_state_t   state;
  uart_state_t   state_nxt;
  logic [BW-1:0] baud_cnt;
  logic [2:0]    bit_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    sr;
  logic [7:0]    fifo_head;
  logic          pop;
  logic          bit_end;
  logic          last_bit;
  logic          line_nxt;
  logic          uart_tx_q;
  logic          ovf_q;

  mfp_uart_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (SI_ClkIn),
    .resetn  (SI_Reset_N),
    .wr      (tx_wr),
    .wr_data (tx_data),
    .rd      (pop),
    .rd_data (fifo_head),
    .full    (tx_full),
    .empty   (tx_empty),
    .count   (tx_count)
  );

  assign bit_end  = (baud_cnt == BAUD_LAST);
  assign last_bit = (bit_cnt == 3'(UART_DATA_BITS - 1));
  assign tx_busy  = (state != ST_IDLE);
  assign tx_ovf   = ovf_q;
  assign UART_TX  = uart_tx_q;

  // State register
  always_ff @(posedge SI_ClkIn) begin
    if (!SI_Reset_N) state <= ST_IDLE;
    else             state <= state_nxt;
  end

  // Next-state: every non-idle bit lasts one full baud period
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (!tx_empty) state_nxt = ST_START;
      ST_START: if (bit_end) state_nxt = ST_DATA;
      ST_DATA:  if (bit_end && last_bit)
`ifdef MFP_UART_TX_PARITY_EN
                  state_nxt = ST_PARITY;
`else
                  state_nxt = ST_STOP;
`endif
`ifdef MFP_UART_TX_PARITY_EN
      ST_PARITY: if (bit_end) state_nxt = ST_STOP;
`endif
      ST_STOP:  if (bit_end) state_nxt = tx_empty ? ST_IDLE : ST_START;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Outputs: pop at frame start, and the line level for the upcoming cycle
  always_comb begin
    pop      = ((state == ST_IDLE) || (state == ST_STOP && bit_end)) && !tx_empty;
    bit_idx  = (state == ST_DATA && bit_end) ? bit_cnt + 3'd1 : bit_cnt;
    line_nxt = 1'b1;
    case (state_nxt)
      ST_START:  line_nxt = 1'b0;
      ST_DATA:   line_nxt = sr[bit_idx];
`ifdef MFP_UART_TX_PARITY_EN
      ST_PARITY: line_nxt = ^sr;
`endif
      default:   line_nxt = 1'b1;
    endcase
  end

  // Datapath: baud/bit counters, byte in flight, registered line, sticky overflow
  always_ff @(posedge SI_ClkIn) begin
    if (!SI_Reset_N) begin
      baud_cnt  <= '0;
      bit_cnt   <= '0;
      sr        <= '0;
      uart_tx_q <= 1'b1;
      ovf_q     <= 1'b0;
    end else begin
      if (state == ST_IDLE || bit_end) baud_cnt <= '0;
      else                             baud_cnt <= baud_cnt + 1'b1;
      if (state != ST_DATA) bit_cnt <= '0;
      else if (bit_end)     bit_cnt <= bit_cnt + 3'd1;
      if (pop) sr <= fifo_head;
      uart_tx_q <= line_nxt;
      if (tx_wr && tx_full) ovf_q <= 1'b1;
      else if (tx_ovf_clr)  ovf_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mfp_uart_tx.sv
// tb/tb_mfp_uart_tx.sv - self-checking bench for mfp_uart_tx with a mid-bit line decoder
module tb_mfp_uart_tx;

  localparam int CLK_FREQ = 1000;
  localparam int BAUD     = 77;
  localparam int DIV      = (CLK_FREQ + BAUD / 2) / BAUD;
  localparam int DEPTH    = 16;
`ifdef MFP_UART_TX_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif
  localparam int FRAME = PAR ? 11 : 10;

  logic       clk = 1'b0;
  logic       SI_Reset_N = 1'b0;
  logic       tx_wr = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_ovf_clr = 1'b0;
  logic       tx_full, tx_empty, tx_busy, tx_ovf, uart_tx;
  logic [4:0] tx_count;

  int cyc = 0;
  int checks = 0;
  int failures = 0;
  bit mon_en = 1'b0;

  typedef struct {
    logic [7:0] data;
    logic       par;
    logic       start_ok;
    logic       stop_ok;
    int         t0;
  } frame_t;
  frame_t rx_q[$];
  frame_t mf;

  typedef struct {
    logic [7:0] data;
    logic       par;
  } vec_t;
  vec_t vecs[7];

  mfp_uart_tx #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .FIFO_DEPTH(DEPTH)) dut (
    .SI_ClkIn   (clk),
    .SI_Reset_N (SI_Reset_N),
    .tx_wr      (tx_wr),
    .tx_data    (tx_data),
    .tx_ovf_clr (tx_ovf_clr),
    .tx_full    (tx_full),
    .tx_empty   (tx_empty),
    .tx_busy    (tx_busy),
    .tx_count   (tx_count),
    .tx_ovf     (tx_ovf),
    .UART_TX    (uart_tx)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Line decoder: detects the start edge, samples every bit at its centre
  initial begin
    forever begin
      @(negedge clk);
      if (mon_en && SI_Reset_N && uart_tx === 1'b0) begin
        mf.t0 = cyc;
        repeat (DIV / 2) @(negedge clk);
        mf.start_ok = (uart_tx == 1'b0);
        for (int i = 0; i < 8; i++) begin
          repeat (DIV) @(negedge clk);
          mf.data[i] = uart_tx;
        end
        mf.par = 1'b0;
        if (PAR) begin
          repeat (DIV) @(negedge clk);
          mf.par = uart_tx;
        end
        repeat (DIV) @(negedge clk);
        mf.stop_ok = (uart_tx == 1'b1);
        rx_q.push_back(mf);
      end
    end
  end

  task automatic write1(input logic [7:0] d, output int k);
    @(posedge clk); #1;
    tx_wr = 1'b1;
    tx_data = d;
    k = cyc;
    @(posedge clk); #1;
    tx_wr = 1'b0;
  endtask

  task automatic wait_frames(input int n, input int budget);
    int w;
    w = 0;
    while (rx_q.size() < n && w < budget) begin
      @(negedge clk);
      w++;
    end
    chk("frame_wait", (rx_q.size() >= n), 1);
  endtask

  task automatic wait_idle(output int t);
    int w;
    w = 0;
    while (tx_busy && w < 20 * FRAME * DIV) begin
      @(negedge clk);
      w++;
    end
    t = cyc;
    chk("idle_wait", tx_busy, 0);
  endtask

  function automatic logic even_par(input logic [7:0] d);
    int n;
    n = 0;
    for (int i = 0; i < 8; i++) n += d[i];
    return logic'(n % 2);
  endfunction

  initial begin
    int k, t, bad, n, gap;
    frame_t f, f1, f2, f3;
    logic [7:0] exp_q[$];
    logic [7:0] b;

    vecs[0] = '{8'h55, 1'b0};
    vecs[1] = '{8'h07, 1'b1};
    vecs[2] = '{8'hA3, 1'b0};
    vecs[3] = '{8'h01, 1'b1};
    vecs[4] = '{8'h80, 1'b1};
    vecs[5] = '{8'hFE, 1'b1};
    vecs[6] = '{8'h3C, 1'b0};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_line", uart_tx, 1);
    chk("rst_empty", tx_empty, 1);
    chk("rst_full", tx_full, 0);
    chk("rst_count", tx_count, 0);
    chk("rst_busy", tx_busy, 0);
    chk("rst_ovf", tx_ovf, 0);
    SI_Reset_N = 1'b1;
    mon_en = 1'b1;

    // Idle line after reset release
    bad = 0;
    repeat (10000) begin
      @(negedge clk);
      if (uart_tx !== 1'b1 || tx_empty !== 1'b1 || tx_busy !== 1'b0) bad++;
    end
    chk("idle_quiet", bad, 0);
    chk("idle_no_frames", rx_q.size(), 0);

    // Single frames: latency, content, parity, stop, busy length
    for (int v = 0; v < 7; v++) begin
      write1(vecs[v].data, k);
      wait_frames(1, 2 * FRAME * DIV);
      if (rx_q.size() > 0) begin
        f = rx_q.pop_front();
        chk($sformatf("v%0d_latency", v), f.t0, k + 2);
        chk($sformatf("v%0d_start", v), f.start_ok, 1);
        chk($sformatf("v%0d_data", v), f.data, vecs[v].data);
        chk($sformatf("v%0d_parity", v), f.par, PAR ? vecs[v].par : 1'b0);
        chk($sformatf("v%0d_stop", v), f.stop_ok, 1);
      end
      wait_idle(t);
      chk($sformatf("v%0d_busy_len", v), t, k + 2 + FRAME * DIV);
    end

    // Back-to-back frames from consecutive writes
    @(posedge clk); #1;
    k = cyc;
    tx_wr = 1'b1;
    tx_data = 8'hA3;
    @(posedge clk); #1;
    chk("b2b_count_k1", tx_count, 1);
    tx_data = 8'h0F;
    @(posedge clk); #1;
    chk("b2b_count_k2", tx_count, 1);
    tx_data = 8'hFF;
    @(posedge clk); #1;
    tx_wr = 1'b0;
    chk("b2b_count_k3", tx_count, 2);
    wait_frames(3, 4 * FRAME * DIV);
    if (rx_q.size() >= 3) begin
      f1 = rx_q.pop_front();
      f2 = rx_q.pop_front();
      f3 = rx_q.pop_front();
      chk("b2b_d0", f1.data, 8'hA3);
      chk("b2b_d1", f2.data, 8'h0F);
      chk("b2b_d2", f3.data, 8'hFF);
      chk("b2b_t0", f1.t0, k + 2);
      chk("b2b_gap1", f2.t0 - f1.t0, FRAME * DIV);
      chk("b2b_gap2", f3.t0 - f2.t0, FRAME * DIV);
    end
    wait_idle(t);
    chk("b2b_count_end", tx_count, 0);

    // Overflow: fill while a frame is in flight
    write1(8'hC3, k);
    repeat (3) @(posedge clk);
    for (int i = 0; i <= 16; i++) begin
      @(posedge clk); #1;
      tx_wr = 1'b1;
      tx_data = 8'(i);
      if (i == 15) chk("ovf_not_full_15", tx_full, 0);
      if (i == 16) chk("ovf_full_16", tx_full, 1);
    end
    @(posedge clk); #1;
    tx_wr = 1'b0;
    chk("ovf_set", tx_ovf, 1);
    chk("ovf_count", tx_count, DEPTH);
    tx_ovf_clr = 1'b1;
    @(posedge clk); #1;
    tx_ovf_clr = 1'b0;
    chk("ovf_clr", tx_ovf, 0);
    tx_ovf_clr = 1'b1;
    tx_wr = 1'b1;
    tx_data = 8'h77;
    @(posedge clk); #1;
    tx_ovf_clr = 1'b0;
    tx_wr = 1'b0;
    chk("ovf_set_wins", tx_ovf, 1);
    tx_ovf_clr = 1'b1;
    @(posedge clk); #1;
    tx_ovf_clr = 1'b0;
    chk("ovf_clr2", tx_ovf, 0);
    wait_frames(17, 19 * FRAME * DIV);
    exp_q.delete();
    exp_q.push_back(8'hC3);
    for (int i = 0; i < 16; i++) exp_q.push_back(8'(i));
    bad = 0;
    while (rx_q.size() > 0 && exp_q.size() > 0) begin
      f = rx_q.pop_front();
      b = exp_q.pop_front();
      if (f.data !== b || !f.stop_ok) bad++;
    end
    chk("ovf_stream_errs", bad, 0);
    chk("ovf_stream_left", exp_q.size(), 0);
    wait_idle(t);
    repeat (2 * FRAME * DIV) @(negedge clk);
    chk("ovf_no_extra", rx_q.size(), 0);

    // Reset mid data bit of 0x00, with more bytes queued
    mon_en = 1'b0;
    @(posedge clk); #1;
    k = cyc;
    tx_wr = 1'b1;
    tx_data = 8'h00;
    @(posedge clk); #1;
    tx_data = 8'h11;
    @(posedge clk); #1;
    tx_data = 8'h22;
    @(posedge clk); #1;
    tx_wr = 1'b0;
    while (cyc < k + 2 + 4 * DIV + DIV / 2) @(posedge clk);
    #1;
    chk("rst_mid_low", uart_tx, 0);
    chk("rst_mid_busy", tx_busy, 1);
    SI_Reset_N = 1'b0;
    @(posedge clk); #1;
    SI_Reset_N = 1'b1;
    chk("rst_mid_line", uart_tx, 1);
    chk("rst_mid_count", tx_count, 0);
    chk("rst_mid_busy0", tx_busy, 0);
    chk("rst_mid_empty", tx_empty, 1);
    bad = 0;
    repeat (3 * FRAME * DIV) begin
      @(negedge clk);
      if (uart_tx !== 1'b1 || tx_busy !== 1'b0) bad++;
    end
    chk("rst_mid_quiet", bad, 0);
    mon_en = 1'b1;

    // Random bursts against a queue model
    for (int r = 0; r < 4; r++) begin
      n = $urandom_range(1, DEPTH);
      exp_q.delete();
      for (int j = 0; j < n; j++) begin
        gap = $urandom_range(0, 3);
        repeat (gap) @(posedge clk);
        b = 8'($urandom);
        exp_q.push_back(b);
        write1(b, k);
      end
      wait_frames(n, (n + 2) * FRAME * DIV);
      bad = 0;
      while (rx_q.size() > 0 && exp_q.size() > 0) begin
        f = rx_q.pop_front();
        b = exp_q.pop_front();
        if (f.data !== b || f.stop_ok !== 1'b1 || f.start_ok !== 1'b1) bad++;
        if (f.par !== (PAR ? even_par(b) : 1'b0)) bad++;
      end
      chk($sformatf("rand%0d_errs", r), bad, 0);
      chk($sformatf("rand%0d_left", r), exp_q.size(), 0);
      wait_idle(t);
    end

    chk("final_no_frames", rx_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
